rng_range_sampler: RTL and testbench

Downstream consumer of the 32-bit LFSR random word. It steps the LFSR on demand through a one-cycle strobe and samples the LFSR output after a settle window. Rejection sampling then turns the word into a uniform value in [0, limit). Requests arrive and results leave over valid/ready handshakes, feeding LED/display logic in the DE10-Nano top level.

---
 rtl/rng_range_sampler_pkg.sv | 14 +
 rtl/rng_range_sampler_if.sv | 26 ++
 rtl/rng_range_mask.sv | 20 ++
 rtl/rng_range_sampler.sv | 111 +++++++++++
 tb/tb_rng_range_sampler.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/rng_range_sampler_pkg.sv
// Shared types and defaults for the bounded-random sampler blocks.
package rng_pkg;
    localparam int RNG_W             = 32;
    localparam int SETTLE_CYCLES_DEF = 2;
    localparam int MAX_TRIES_DEF     = 16;

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        SETTLE,
        CHECK,
        HOLD
    } sampler_state_e;
endpackage

// File: rtl/rng_range_sampler_if.sv
// Request/result handshakes plus the LFSR step/sample pair of the sampler.
interface rng_range_sampler_if
    import rng_pkg::*;
#(
    parameter int W = RNG_W
);
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_limit;
    logic [W-1:0] rng;
    logic         lfsr_pulse;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_value;
    logic         out_fallback;

    modport slave (
        input  req_valid, req_limit, rng, out_ready,
        output req_ready, lfsr_pulse, out_valid, out_value, out_fallback
    );

    modport master (
        output req_valid, req_limit, rng, out_ready,
        input  req_ready, lfsr_pulse, out_valid, out_value, out_fallback
    );
endinterface

// File: rtl/rng_range_mask.sv
// Smallest all-ones mask covering limit-1; limit==0 selects the full word.
module rng_range_mask
    import rng_pkg::*;
#(
    parameter int W = RNG_W
) (
    input  logic [W-1:0] i_limit,
    output logic [W-1:0] o_mask
);
    logic [W-1:0] w_smear;

    // Smearing the top set bit of limit-1 downward yields 2^k-1 >= limit-1.
    always_comb begin
        w_smear = i_limit - 1'b1;
        for (int s = 1; s < W; s = s * 2) begin
            w_smear = w_smear | (w_smear >> s);
        end
        o_mask = (i_limit == '0) ? '1 : w_smear;
    end
endmodule

// File: rtl/rng_range_sampler.sv
// Steps the LFSR on demand and rejection-samples its word into [0, limit).
module rng_range_sampler
    import rng_pkg::*;
#(
    parameter int W             = RNG_W,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int MAX_TRIES     = MAX_TRIES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    rng_range_sampler_if.slave  bus
);
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [TW-1:0] TRIES_LAST  = TW'(MAX_TRIES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    sampler_state_e r_state;
    logic [W-1:0]   r_limit;
    logic [TW-1:0]  r_tries;
    logic [SW-1:0]  r_settle;
    logic           r_req_ready;
    logic           r_pulse;
    logic           r_out_valid;
    logic [W-1:0]   r_out_value;
    logic           r_out_fallback;

    logic [W-1:0]   w_mask;
    logic [W-1:0]   w_cand;
    logic           w_accept;

    rng_range_mask #(.W(W)) u_mask (
        .i_limit (r_limit),
        .o_mask  (w_mask)
    );

    assign w_cand   = bus.rng & w_mask;
    assign w_accept = (r_limit == '0) || (w_cand < r_limit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_limit        <= '0;
            r_tries        <= '0;
            r_settle       <= '0;
            r_req_ready    <= 1'b1;
            r_pulse        <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_value    <= '0;
            r_out_fallback <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_limit     <= bus.req_limit;
                        r_tries     <= '0;
                        r_req_ready <= 1'b0;
                        r_pulse     <= 1'b1;
                        r_state     <= PULSE;
                    end
                end
                PULSE: begin
                    r_pulse  <= 1'b0;
                    r_tries  <= r_tries + 1'b1;
                    r_settle <= '0;
                    r_state  <= SETTLE;
                end
                SETTLE: begin
                    if (r_settle == SETTLE_LAST) begin
                        r_state <= CHECK;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                CHECK: begin
                    if (w_accept) begin
                        r_out_value    <= w_cand;
                        r_out_fallback <= 1'b0;
                        r_out_valid    <= 1'b1;
                        r_state        <= HOLD;
                    end else if (r_tries < TRIES_LAST) begin
                        r_pulse <= 1'b1;
                        r_state <= PULSE;
                    end else begin
                        // cand <= mask < 2*limit, so this stays below limit
                        r_out_value    <= w_cand - r_limit;
                        r_out_fallback <= 1'b1;
                        r_out_valid    <= 1'b1;
                        r_state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = r_req_ready;
    assign bus.lfsr_pulse   = r_pulse;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_value    = r_out_value;
    assign bus.out_fallback = r_out_fallback;
endmodule

// File: tb/tb_rng_range_sampler.sv
// Directed and randomized requests against an arithmetic rejection-sampling model.
module tb_rng_range_sampler;
    import rng_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rng_range_sampler_if #(.W(RNG_W)) bus ();

    rng_range_sampler #(.W(RNG_W), .SETTLE_CYCLES(2), .MAX_TRIES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] words [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample t (1-based) sees words[t-1]; mask is the smallest 2^k-1 that reaches limit-1.
    function automatic void model(input logic [31:0] lim, output logic [31:0] val,
                                  output logic fb, output int np);
        logic [63:0] m;
        logic [31:0] c;
        val = '0; fb = 1'b0; np = 0;
        if (lim == 0) m = 64'hFFFF_FFFF;
        else begin
            m = 0;
            while (m + 1 < {32'd0, lim}) m = m * 2 + 1;
        end
        for (int t = 1; t <= 16; t++) begin
            c = words[t-1] & m[31:0];
            if (lim == 0 || c < lim) begin
                val = c; fb = 1'b0; np = t;
                return;
            end
            if (t == 16) begin
                val = c - lim; fb = 1'b1; np = 16;
            end
        end
    endfunction

    task automatic run_req(input string tag, input logic [31:0] lim, input int hold);
        logic [31:0] ev, v0;
        logic        efb, f0, stable, done;
        int          enp, n, np, wi;
        model(lim, ev, efb, enp);
        @(negedge clk);
        chk({tag, ".req_ready"}, bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_limit = lim;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_limit = $urandom;
        // the accept edge counts as cycle 1 of the latency
        n = 0; np = 0; wi = 0; done = 1'b0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
            if (bus.lfsr_pulse) begin
                np++;
                bus.rng = words[(wi < 16) ? wi : 15];
                wi++;
            end
            if (bus.out_valid) done = 1'b1;
        end
        chk({tag, ".done"}, done, 1);
        chk({tag, ".latency"}, n, 5 + 4 * (enp - 1));
        chk({tag, ".pulses"}, np, enp);
        chk({tag, ".value"}, bus.out_value, ev);
        chk({tag, ".fallback"}, bus.out_fallback, efb);
        v0 = bus.out_value;
        f0 = bus.out_fallback;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_limit = $urandom;
            if (bus.out_value !== v0 || bus.out_fallback !== f0 || bus.out_valid !== 1'b1 ||
                bus.lfsr_pulse !== 1'b0 || bus.req_ready !== 1'b0) stable = 1'b0;
        end
        chk({tag, ".hold_stable"}, stable, 1);
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk({tag, ".released"}, {bus.out_valid, bus.req_ready, bus.lfsr_pulse}, 3'b010);
    endtask

    initial begin
        logic [31:0] lim;
        rst = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_limit = '0;
        bus.rng = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("reset", {bus.req_ready, bus.lfsr_pulse, bus.out_valid, bus.out_fallback, bus.out_value},
            {4'b1000, 32'd0});
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) words[i] = 32'h0000_0007;
        run_req("first_try", 32'd10, 0);

        for (int i = 0; i < 16; i++) words[i] = 32'h3;
        words[0] = 32'hD; words[1] = 32'hD;
        run_req("two_rejects", 32'd10, 0);

        for (int i = 0; i < 16; i++) words[i] = 32'hFFFF_FFFF;
        run_req("fallback", 32'd10, 0);

        for (int i = 0; i < 16; i++) words[i] = 32'hDEAD_BEEF;
        run_req("limit0", 32'd0, 0);

        for (int i = 0; i < 16; i++) words[i] = $urandom;
        run_req("limit1", 32'd1, 0);

        for (int i = 0; i < 16; i++) words[i] = $urandom;
        run_req("backpressure", 32'd100, 20);

        // reset while settling abandons the request
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_limit = 32'd10;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid", {bus.req_ready, bus.lfsr_pulse, bus.out_valid, bus.out_fallback, bus.out_value},
            {4'b1000, 32'd0});
        @(negedge clk);
        chk("rst_held", {bus.lfsr_pulse, bus.out_valid}, 2'b00);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) words[i] = 32'd2;
        run_req("after_rst", 32'd4, 0);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 4))
                0: lim = $urandom_range(1, 20);
                1: lim = $urandom;
                2: lim = 32'd0;
                3: lim = (32'd1 << $urandom_range(0, 30)) + 32'd1;
                default: lim = $urandom_range(2, 1000);
            endcase
            for (int i = 0; i < 16; i++) words[i] = $urandom;
            if ($urandom_range(0, 5) == 0 && lim > 1)
                for (int i = 0; i < 16; i++) words[i] = 32'hFFFF_FFFF;
            run_req("random", lim, $urandom_range(0, 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
